// File: rtl/reg_cmd_ctrl.sv
// reg_cmd_ctrl: byte-command front end for a small register file.
//   0xAA addr dlo dhi -> one-cycle register write
//   0xBB addr         -> one-cycle register read, result sent back as lo then hi byte
// Optional inter-byte timeout in the argument-wait states: define REG_CMD_TIMEOUT_EN.
module reg_cmd_ctrl #(
   parameter int WIDTH   = 16,
   parameter int DEPTH   = 8,
   parameter int AddrW   = 3,
   parameter int TIMEOUT = 255
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [7:0]       RX_P_DATA,
   input  logic             RX_D_VLD,
   input  logic [WIDTH-1:0] RdData,
   input  logic             TX_BUSY,
   output logic             WrEn,
   output logic             RdEn,
   output logic [AddrW-1:0] Address,
   output logic [WIDTH-1:0] WrData,
   output logic [7:0]       TX_P_DATA,
   output logic             TX_D_VLD,
   output logic             ERR,
   output logic             CTRL_BUSY
);

   // Byte-lane slicing below assumes a 16-bit register and an address that fits in one byte.
   if (WIDTH != 16 || AddrW >= 8 || DEPTH > (1 << AddrW) || TIMEOUT < 1) begin : g_cfg_check
      $error("reg_cmd_ctrl: unsupported parameter set");
   end

   localparam logic [7:0] CMD_WR = 8'hAA;
   localparam logic [7:0] CMD_RD = 8'hBB;

   typedef enum logic [3:0] {
      IDLE, W_ADDR, W_DLO, W_DHI, WRITE, R_ADDR, READ, R_WAIT, TX_LO, TX_HI
   } state_t;

   state_t             state_q, state_d;
   logic [AddrW-1:0]   addr_q, addr_d;
   logic [WIDTH-1:0]   wdata_q, wdata_d;
   logic [WIDTH-1:0]   cap_q, cap_d;
   logic               err_q, err_d;
   logic               addr_bad;

`ifdef REG_CMD_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0]      tmo_q, tmo_d;
   logic               waiting;
`endif

   // Any address byte bit above the register-file range makes the command invalid.
   assign addr_bad = |(RX_P_DATA >> AddrW);

   // Next-state and datapath capture; strobes fall out of the state decode below.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cap_d   = cap_q;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (RX_D_VLD) begin
               if (RX_P_DATA == CMD_WR)      state_d = W_ADDR;
               else if (RX_P_DATA == CMD_RD) state_d = R_ADDR;
               else                          err_d   = 1'b1;
            end
         end
         W_ADDR, R_ADDR: begin
            if (RX_D_VLD) begin
               addr_d = RX_P_DATA[AddrW-1:0];
               if (addr_bad) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = (state_q == W_ADDR) ? W_DLO : READ;
               end
            end
         end
         W_DLO: begin
            if (RX_D_VLD) begin
               wdata_d[7:0] = RX_P_DATA;
               state_d      = W_DHI;
            end
         end
         W_DHI: begin
            if (RX_D_VLD) begin
               wdata_d[15:8] = RX_P_DATA;
               state_d       = WRITE;
            end
         end
         WRITE:  state_d = IDLE;
         READ:   state_d = R_WAIT;
         // Register file answers one cycle after the read strobe.
         R_WAIT: begin
            cap_d   = RdData;
            state_d = TX_LO;
         end
         TX_LO:  if (!TX_BUSY) state_d = TX_HI;
         TX_HI:  if (!TX_BUSY) state_d = IDLE;
         default: state_d = IDLE;
      endcase

`ifdef REG_CMD_TIMEOUT_EN
      // Stalled argument phase: abandon the command once TIMEOUT idle cycles have passed.
      waiting = (state_q == W_ADDR) || (state_q == W_DLO) ||
                (state_q == W_DHI)  || (state_q == R_ADDR);
      tmo_d   = '0;
      if (waiting && !RX_D_VLD) begin
         if (tmo_q == TW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = IDLE;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
`endif
   end

   // State and capture registers; reset discards any partial command.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         cap_q   <= '0;
         err_q   <= 1'b0;
`ifdef REG_CMD_TIMEOUT_EN
         tmo_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cap_q   <= cap_d;
         err_q   <= err_d;
`ifdef REG_CMD_TIMEOUT_EN
         tmo_q   <= tmo_d;
`endif
      end
   end

   assign WrEn      = (state_q == WRITE);
   assign RdEn      = (state_q == READ);
   assign Address   = addr_q;
   assign WrData    = wdata_q;
   assign TX_D_VLD  = (state_q == TX_LO) || (state_q == TX_HI);
   assign TX_P_DATA = (state_q == TX_LO) ? cap_q[7:0]  :
                      (state_q == TX_HI) ? cap_q[15:8] : 8'h00;
   assign ERR       = err_q;
   assign CTRL_BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Scoreboard bench for reg_cmd_ctrl: stimulus pushes expected register accesses,
// TX transfers and error pulses; a negedge monitor pops and compares them.
// Build with REG_CMD_TIMEOUT_EN to also exercise the timeout (TIMEOUT=10).
module tb_reg_cmd_ctrl;
   localparam int AW = 3;
`ifdef REG_CMD_TIMEOUT_EN
   localparam int TMO = 10;
`else
   localparam int TMO = 255;
`endif
   localparam logic [1:0] K_WR = 2'd0, K_RD = 2'd1, K_TX = 2'd2, K_ERR = 2'd3;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [7:0]    RX_P_DATA = 8'h00;
   logic          RX_D_VLD = 1'b0;
   logic [15:0]   RdData;
   logic          TX_BUSY = 1'b0;
   logic          WrEn, RdEn, TX_D_VLD, ERR, CTRL_BUSY;
   logic [AW-1:0] Address;
   logic [15:0]   WrData;
   logic [7:0]    TX_P_DATA;

   typedef struct packed {
      logic [1:0]  kind;
      logic [31:0] val;
   } ev_t;

   ev_t exp_q[$];
   int  checks   = 0;
   int  failures = 0;

   always #5 CLK = ~CLK;

   reg_cmd_ctrl #(.WIDTH(16), .DEPTH(8), .AddrW(AW), .TIMEOUT(TMO)) dut (
      .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
      .RdData(RdData), .TX_BUSY(TX_BUSY), .WrEn(WrEn), .RdEn(RdEn),
      .Address(Address), .WrData(WrData), .TX_P_DATA(TX_P_DATA),
      .TX_D_VLD(TX_D_VLD), .ERR(ERR), .CTRL_BUSY(CTRL_BUSY)
   );

   // Register-file model: write on strobe, read data one cycle after RdEn.
   logic [15:0] mem [8];
   always @(posedge CLK) begin
      if (WrEn) mem[Address] <= WrData;
      if (RdEn) RdData <= mem[Address];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic observe(input logic [1:0] k, input logic [31:0] v, input string nm);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL %s unexpected event actual=%h required=none", nm, v);
      end else begin
         e = exp_q.pop_front();
         if (e.kind !== k || e.val !== v) begin
            failures++;
            $display("FAIL %s actual kind=%0d val=%h required kind=%0d val=%h",
                     nm, k, v, e.kind, e.val);
         end
      end
   endtask

   function automatic void push(input logic [1:0] k, input logic [31:0] v);
      exp_q.push_back('{kind: k, val: v});
   endfunction

   // Monitor: every observable DUT action must match the head of the scoreboard.
   always @(negedge CLK) begin
      if (!RST) begin
         chk("wr_rd_exclusive", {31'b0, WrEn & RdEn}, 32'd0);
         if (WrEn)                 observe(K_WR, {16'(Address), WrData}, "write");
         if (RdEn)                 observe(K_RD, 32'(Address), "read");
         if (TX_D_VLD && !TX_BUSY) observe(K_TX, 32'(TX_P_DATA), "tx_byte");
         if (ERR)                  observe(K_ERR, 32'd0, "err_pulse");
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge CLK); #1;
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      @(posedge CLK); #1;
      RX_D_VLD  = 1'b0;
   endtask

   task automatic wait_idle(input string nm, input int maxc);
      int n = 0;
      while ((CTRL_BUSY || exp_q.size() != 0) && n < maxc) begin
         @(negedge CLK);
         n++;
      end
      chk({nm, "_drained"}, {31'b0, CTRL_BUSY || exp_q.size() != 0}, 32'd0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_WrEn"},      32'(WrEn),      32'd0);
      chk({tag, "_RdEn"},      32'(RdEn),      32'd0);
      chk({tag, "_Address"},   32'(Address),   32'd0);
      chk({tag, "_WrData"},    32'(WrData),    32'd0);
      chk({tag, "_TX_P_DATA"}, 32'(TX_P_DATA), 32'd0);
      chk({tag, "_TX_D_VLD"},  32'(TX_D_VLD),  32'd0);
      chk({tag, "_ERR"},       32'(ERR),       32'd0);
      chk({tag, "_CTRL_BUSY"}, 32'(CTRL_BUSY), 32'd0);
   endtask

   initial begin
      int n;
      // Reset state
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk_zero("reset");
      @(posedge CLK); #1;
      RST = 1'b0;

      // Write 0x0027 to address 5, then read it back as two TX bytes
      push(K_WR, {16'd5, 16'h0027});
      send_byte(8'hAA); send_byte(8'h05); send_byte(8'h27); send_byte(8'h00);
      wait_idle("write5", 20);
      push(K_RD, 32'd5);
      push(K_TX, 32'h27);
      push(K_TX, 32'h00);
      send_byte(8'hBB); send_byte(8'h05);
      wait_idle("read5", 20);

      // Unknown command byte
      push(K_ERR, 32'd0);
      send_byte(8'h3C);
      wait_idle("badcmd", 10);
      chk("badcmd_idle", 32'(CTRL_BUSY), 32'd0);

      // Out-of-range read address
      push(K_ERR, 32'd0);
      send_byte(8'hBB); send_byte(8'h09);
      wait_idle("badaddr", 10);

      // Read 0xBEEF with the transmitter stalled for 20 cycles
      push(K_WR, {16'd6, 16'hBEEF});
      send_byte(8'hAA); send_byte(8'h06); send_byte(8'hEF); send_byte(8'hBE);
      wait_idle("write6", 20);
      TX_BUSY = 1'b1;
      push(K_RD, 32'd6);
      push(K_TX, 32'hEF);
      push(K_TX, 32'hBE);
      send_byte(8'hBB); send_byte(8'h06);
      n = 0;
      while (!TX_D_VLD && n < 20) begin
         @(negedge CLK);
         n++;
      end
      chk("busy_tx_vld_seen", 32'(TX_D_VLD), 32'd1);
      for (int i = 0; i < 20; i++) begin
         @(posedge CLK); #1;
         RX_D_VLD  = (i == 5) || (i == 10);
         RX_P_DATA = (i == 5) ? 8'hAA : 8'h3C;
         @(negedge CLK);
         chk("busy_hold_data", 32'(TX_P_DATA), 32'hEF);
         chk("busy_hold_vld",  32'(TX_D_VLD),  32'd1);
         chk("busy_no_err",    32'(ERR),       32'd0);
      end
      @(posedge CLK); #1;
      RX_D_VLD = 1'b0;
      TX_BUSY  = 1'b0;
      wait_idle("busy_release", 20);

      // Reset mid-command (with a command byte presented during reset)
      send_byte(8'hAA); send_byte(8'h02);
      @(posedge CLK); #1;
      RST       = 1'b1;
      RX_D_VLD  = 1'b1;
      RX_P_DATA = 8'hAA;
      @(posedge CLK); #1;
      RST      = 1'b0;
      RX_D_VLD = 1'b0;
      @(negedge CLK);
      chk_zero("midreset");
      push(K_WR, {16'd3, 16'h1234});
      send_byte(8'hAA); send_byte(8'h03); send_byte(8'h34); send_byte(8'h12);
      wait_idle("write3", 20);

`ifdef REG_CMD_TIMEOUT_EN
      // Stalled write command: ERR exactly TIMEOUT cycles after the last byte
      push(K_ERR, 32'd0);
      send_byte(8'hAA);
      n = 0;
      while (!ERR && n < 30) begin
         @(posedge CLK); #1;
         n++;
      end
      chk("timeout_cycles", 32'(n), 32'd10);
      wait_idle("timeout", 5);
      chk("timeout_idle", 32'(CTRL_BUSY), 32'd0);
`endif

      repeat (3) @(negedge CLK);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog simulation did not complete");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/reg_cmd_ctrl.md
REG_CMD_CTRL -- requirements
Module: reg_cmd_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16: register data width; only 16 is supported.
REQ-002 SHALL have parameter DEPTH, default 8: number of register-file entries.
REQ-003 SHALL have parameter AddrW, default 3: register-file address width.
REQ-004 SHALL have parameter TIMEOUT, default 255: inter-byte timeout in cycles (used only with REQ-032).
REQ-005 SHALL have port CLK, input, 1: single clock; all logic on rising edge.
REQ-006 SHALL have port RST, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port RX_P_DATA, input, 8: received command byte.
REQ-008 SHALL have port RX_D_VLD, input, 1: one-cycle pulse qualifying RX_P_DATA.
REQ-009 SHALL have port RdData, input, WIDTH: register-file read data, valid the cycle after RdEn.
REQ-010 SHALL have port TX_BUSY, input, 1: transmitter cannot accept a byte.
REQ-011 SHALL have port WrEn, output, 1: register-file write strobe.
REQ-012 SHALL have port RdEn, output, 1: register-file read strobe.
REQ-013 SHALL have port Address, output, AddrW: register-file address.
REQ-014 SHALL have port WrData, output, WIDTH: register-file write data.
REQ-015 SHALL have port TX_P_DATA, output, 8: byte to transmit.
REQ-016 SHALL have port TX_D_VLD, output, 1: TX_P_DATA valid; held until accepted.
REQ-017 SHALL have port ERR, output, 1: one-cycle pulse on a protocol error.
REQ-018 SHALL have port CTRL_BUSY, output, 1: high in every state except IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, W_ADDR, W_DLO, W_DHI, WRITE, R_ADDR, READ, R_WAIT, TX_LO, TX_HI.
REQ-020 SHALL, in IDLE on RX_D_VLD: 0xAA -> W_ADDR; 0xBB -> R_ADDR; any other byte -> ERR pulse next cycle, stay IDLE.
REQ-021 SHALL, in W_ADDR/R_ADDR on RX_D_VLD: latch RX_P_DATA[AddrW-1:0] as Address; if any RX_P_DATA[7:AddrW] bit is set -> ERR pulse, IDLE, no access.
REQ-022 SHALL, in W_DLO on RX_D_VLD, latch WrData[7:0]; in W_DHI on RX_D_VLD, latch WrData[15:8] and go to WRITE.
REQ-023 SHALL hold WrEn high for exactly one cycle in WRITE, with Address/WrData stable, then return to IDLE.
REQ-024 SHALL hold RdEn high for exactly one cycle in READ, then spend one cycle in R_WAIT and capture RdData at the end of R_WAIT.
REQ-025 SHALL, in TX_LO, drive TX_P_DATA = captured[7:0] with TX_D_VLD=1; SHALL, in TX_HI, drive captured[15:8]; a byte transfers on a cycle with TX_D_VLD=1 and TX_BUSY=0.
REQ-026 SHALL advance TX_LO->TX_HI->IDLE only on transfer; TX_P_DATA SHALL stay stable while TX_BUSY=1.
REQ-027 SHALL ignore and drop RX_D_VLD bytes in WRITE, READ, R_WAIT, TX_LO and TX_HI.
REQ-028 SHALL keep WrEn and RdEn mutually exclusive, never both high.
REQ-029 SHALL keep states between RX bytes indefinitely while RX_D_VLD=0 (unless REQ-032 is enabled).

Reset
REQ-030 SHALL, when RST=1 at a clock edge (including mid-command or mid-transmit), enter IDLE and drive WrEn=0, RdEn=0, Address=0, WrData=0, TX_P_DATA=0, TX_D_VLD=0, ERR=0, CTRL_BUSY=0; the partial command is discarded.
REQ-031 SHALL treat RX_D_VLD sampled in the reset cycle as not received.

Configuration
REQ-032 SHALL, with macro REG_CMD_TIMEOUT_EN defined, count cycles without RX_D_VLD in W_ADDR, W_DLO, W_DHI and R_ADDR; when the count reaches TIMEOUT, it SHALL pulse ERR and return to IDLE; the counter clears on every RX byte and state change.
REQ-033 SHALL, without REG_CMD_TIMEOUT_EN, contain no timeout counter, and behaviour SHALL be per REQ-029.

Verification
REQ-034 SHALL cover: RX 0xAA,0x05,0x27,0x00 -> one-cycle WrEn with Address=5 and WrData=0x0027; then RX 0xBB,0x05 with the model returning 0x0027 -> TX bytes 0x27 then 0x00.
REQ-035 SHALL cover: RX 0x3C in IDLE -> one ERR pulse, no WrEn/RdEn, stays IDLE.
REQ-036 SHALL cover: RX 0xBB,0x09 -> ERR pulse, no RdEn, IDLE.
REQ-037 SHALL cover: read of 0xBEEF with TX_BUSY=1 for 20 cycles -> TX_P_DATA=0xEF held with TX_D_VLD=1, then 0xBE sent after release; extra RX bytes meanwhile dropped.
REQ-038 SHALL cover: RST=1 after RX 0xAA,0x02 -> all outputs zero next cycle; a following full write to address 3 works normally.
REQ-039 SHALL cover, with REG_CMD_TIMEOUT_EN and TIMEOUT=10: RX 0xAA then idle -> ERR exactly 10 cycles later, IDLE, no WrEn.
